dc_motor_ctrl: RTL and testbench

Sequencing controller placed in front of `DC_MOTOR`. It converts a signed speed setpoint into the motor's `enable`/`cw`/`ccw`/`value` command set. It enforces a speed ramp and a ramp-to-zero plus dead time on every direction reversal. It also supervises the current ADC, with an overcurrent trip, timed auto-retry and a lockout after repeated faults.

---
 rtl/dc_motor_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_dc_motor_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_motor_ctrl.sv
// Sequencing controller in front of DC_MOTOR: signed setpoint to enable/cw/ccw/value,
// with speed ramp, dead time on reversal and overcurrent trip / retry / lockout.
module dc_motor_ctrl #(
  parameter int RAMP_DIV    = 1000,
  parameter int RAMP_STEP   = 8,
  parameter int DEAD_TIME   = 500,
  parameter int FAULT_RETRY = 50000,
  parameter int MAX_FAULTS  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [14:0] setpoint,
  input  logic        setpoint_valid,
  input  logic [11:0] adc,
  input  logic [11:0] adc_cmp,
  input  logic        adc_latch,
  input  logic        clear_fault,
  output logic        enable,
  output logic        cw,
  output logic        ccw,
  output logic [11:0] value,
  output logic [2:0]  state,
  output logic        fault,
  output logic        busy
);

  localparam int PW   = $clog2(RAMP_DIV + 1);
  localparam int TMAX = (DEAD_TIME > FAULT_RETRY) ? DEAD_TIME : FAULT_RETRY;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int OW   = $clog2(DEAD_TIME + 1);
  localparam logic [11:0] STEP = 12'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DEAD  = 3'd2,
    S_FAULT = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [14:0]   sp_q, sp_d;
  logic          dir_q, dir_d;
  logic [11:0]   value_q, value_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    count_q, count_d;
  logic          lock_q, lock_d;
  logic          armed_q, armed_d;
  logic [OW-1:0] off_q, off_d;
  logic          enable_q, enable_d;
  logic          cw_q, cw_d;
  logic          ccw_q, ccw_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;

  logic [14:0]   sp_abs_s;
  logic [11:0]   mag_s;
  logic          sp_nz_s;
  logic          opposes_s;
  logic          reversal_s;
  logic [11:0]   tgt_s;
  logic [11:0]   diff_s;
  logic [11:0]   step_s;
  logic [11:0]   ramped_s;
  logic          trip_s;
  logic [3:0]    cnt_inc_s;
  logic          off_sat_s;
  logic          start_ok_s;

  // Setpoint decode: saturated magnitude and effective ramp target
  always_comb begin
    sp_abs_s   = sp_q[14] ? (~sp_q + 15'd1) : sp_q;
    mag_s      = (sp_abs_s > 15'd4095) ? 12'hFFF : sp_abs_s[11:0];
    sp_nz_s    = (sp_q != 15'd0);
    opposes_s  = sp_nz_s && (sp_q[14] != dir_q);
    reversal_s = run && opposes_s;
    if (!run || !sp_nz_s || opposes_s) begin
      tgt_s = 12'd0;
    end else begin
      tgt_s = mag_s;
    end
  end

  // One ramp step toward the target, clamped so it never overshoots
  always_comb begin
    if (tgt_s >= value_q) begin
      diff_s = tgt_s - value_q;
    end else begin
      diff_s = value_q - tgt_s;
    end
    step_s = (diff_s > STEP) ? STEP : diff_s;
    if (tgt_s >= value_q) begin
      ramped_s = value_q + step_s;
    end else begin
      ramped_s = value_q - step_s;
    end
  end

  // Fault qualification and restart guard
  always_comb begin
    trip_s     = adc_latch && (adc > adc_cmp);
    cnt_inc_s  = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
    off_sat_s  = (off_q >= OW'(DEAD_TIME - 1));
    // A restart from IDLE in the opposite direction still honours the dead time
    start_ok_s = !armed_q || (sp_q[14] == dir_q) || off_sat_s;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    value_d = value_q;
    presc_d = presc_q;
    timer_d = timer_q;
    lock_d  = lock_q;
    armed_d = armed_q;
    count_d = clear_fault ? 4'd0 : count_q;
    if (setpoint_valid && (state_q != S_LOCK)) begin
      sp_d = setpoint;
    end else begin
      sp_d = sp_q;
    end
    if (state_q == S_RUN) begin
      off_d = '0;
    end else if (off_sat_s) begin
      off_d = off_q;
    end else begin
      off_d = off_q + OW'(1);
    end

    case (state_q)
      S_IDLE: begin
        value_d = 12'd0;
        if (run && sp_nz_s && start_ok_s) begin
          state_d = S_RUN;
          dir_d   = sp_q[14];
          presc_d = '0;
          armed_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (adc_latch && trip_s) begin
          state_d = S_FAULT;
          value_d = 12'd0;
          timer_d = '0;
          count_d = cnt_inc_s;
          lock_d  = (cnt_inc_s >= 4'(MAX_FAULTS));
        end else if ((value_q == 12'd0) && (tgt_s == 12'd0)) begin
          timer_d = '0;
          state_d = reversal_s ? S_DEAD : S_IDLE;
        end else if (presc_q == PW'(RAMP_DIV - 1)) begin
          presc_d = '0;
          value_d = ramped_s;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_DEAD: begin
        value_d = 12'd0;
        if (timer_q == TW'(DEAD_TIME - 1)) begin
          timer_d = '0;
          if (run && sp_nz_s) begin
            state_d = S_RUN;
            dir_d   = sp_q[14];
            presc_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_FAULT: begin
        value_d = 12'd0;
        if (timer_q == TW'(FAULT_RETRY - 1)) begin
          timer_d = '0;
          state_d = lock_q ? S_LOCK : S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOCK: begin
        value_d = 12'd0;
        if (clear_fault) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOCK;
        end
      end
      default: begin
        state_d = S_IDLE;
        value_d = 12'd0;
      end
    endcase

    enable_d = (state_d == S_RUN);
    cw_d     = enable_d && !dir_d;
    ccw_d    = enable_d && dir_d;
    fault_d  = (state_d == S_FAULT) || (state_d == S_LOCK);
    busy_d   = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sp_q     <= 15'd0;
      dir_q    <= 1'b0;
      value_q  <= 12'd0;
      presc_q  <= '0;
      timer_q  <= '0;
      count_q  <= 4'd0;
      lock_q   <= 1'b0;
      armed_q  <= 1'b0;
      off_q    <= '0;
      enable_q <= 1'b0;
      cw_q     <= 1'b0;
      ccw_q    <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      dir_q    <= dir_d;
      value_q  <= value_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      lock_q   <= lock_d;
      armed_q  <= armed_d;
      off_q    <= off_d;
      enable_q <= enable_d;
      cw_q     <= cw_d;
      ccw_q    <= ccw_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
    end
  end

  assign enable = enable_q;
  assign cw     = cw_q;
  assign ccw    = ccw_q;
  assign value  = value_q;
  assign state  = state_q;
  assign fault  = fault_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_dc_motor_ctrl.sv
// Bench for dc_motor_ctrl: directed scenarios plus randomized run, all checked
// against a cycle-level behavioural model of the controller's rules.
module tb_dc_motor_ctrl;
  localparam int RD = 4;
  localparam int RS = 8;
  localparam int DT = 10;
  localparam int FR = 20;
  localparam int MF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [14:0] setpoint = 15'd0;
  logic        setpoint_valid = 1'b0;
  logic [11:0] adc = 12'd0;
  logic [11:0] adc_cmp = 12'd3000;
  logic        adc_latch = 1'b0;
  logic        clear_fault = 1'b0;
  logic        enable, cw, ccw, fault, busy;
  logic [11:0] value;
  logic [2:0]  state;

  dc_motor_ctrl #(
    .RAMP_DIV(RD), .RAMP_STEP(RS), .DEAD_TIME(DT), .FAULT_RETRY(FR), .MAX_FAULTS(MF)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .setpoint(setpoint),
    .setpoint_valid(setpoint_valid), .adc(adc), .adc_cmp(adc_cmp),
    .adc_latch(adc_latch), .clear_fault(clear_fault), .enable(enable),
    .cw(cw), .ccw(ccw), .value(value), .state(state), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: states 0..4, direction +1/-1, countdown timers
  int m_state, m_value, m_dir, m_sp, m_run_clk, m_left, m_count, m_zero;
  bit m_lock, m_armed;

  wire [19:0] act_vec = {state, enable, cw, ccw, fault, busy, value};

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sgn(int a);
    return (a > 0) ? 1 : -1;
  endfunction

  function automatic logic [19:0] exp_vec();
    logic en;
    en = (m_state == 1);
    return {3'(m_state), en, en && (m_dir > 0), en && (m_dir < 0),
            (m_state == 3) || (m_state == 4), m_state != 0, 12'(m_value)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_value = 0; m_dir = 1; m_sp = 0; m_run_clk = 0;
    m_left = 0; m_count = 0; m_zero = 0; m_lock = 0; m_armed = 0;
  endtask

  task automatic model_edge();
    int mag, tgt, nxt, new_count, d;
    bit opp, was_off;
    mag = imin((m_sp < 0) ? -m_sp : m_sp, 4095);
    opp = (m_sp > 0 && m_dir < 0) || (m_sp < 0 && m_dir > 0);
    tgt = (!run || m_sp == 0 || opp) ? 0 : mag;
    new_count = clear_fault ? 0 : m_count;
    was_off = (m_state != 1);
    nxt = m_state;
    case (m_state)
      0: if (run && m_sp != 0 && (!m_armed || sgn(m_sp) == m_dir || m_zero + 1 >= DT)) begin
           nxt = 1; m_dir = sgn(m_sp); m_run_clk = 0; m_armed = 1;
         end
      1: if (adc_latch && adc > adc_cmp) begin
           nxt = 3; m_value = 0; m_left = FR;
           new_count = imin(m_count + 1, 15);
           m_lock = (new_count >= MF);
         end else if (m_value == 0 && tgt == 0) begin
           nxt = (run && opp) ? 2 : 0; m_left = DT;
         end else begin
           m_run_clk++;
           if (m_run_clk % RD == 0) begin
             d = tgt - m_value;
             m_value += (d >= 0) ? imin(d, RS) : -imin(-d, RS);
           end
         end
      2: begin
           m_left--;
           if (m_left == 0) begin
             if (run && m_sp != 0) begin
               nxt = 1; m_dir = sgn(m_sp); m_run_clk = 0;
             end else nxt = 0;
           end
         end
      3: begin
           m_left--;
           if (m_left == 0) nxt = m_lock ? 4 : 0;
         end
      default: if (clear_fault) nxt = 0;
    endcase
    m_zero = was_off ? m_zero + 1 : 0;
    m_count = new_count;
    if (setpoint_valid && m_state != 4) m_sp = int'($signed(setpoint));
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic load_sp(input logic [14:0] v);
    setpoint = v; setpoint_valid = 1'b1;
    tick();
    setpoint_valid = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    n_cmp++;
    if (act_vec !== 20'h0) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", act_vec, 20'h0);
    end
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    n_cmp++;
    if (act_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_release: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_ramp_up();
    load_sp(15'd100);
    run = 1'b1;
    tick();
    n_cmp++;
    if ({state, enable, cw, ccw, value} !== {3'd1, 1'b1, 1'b1, 1'b0, 12'd0}) begin
      n_err++; $display("FAIL ramp_start: got st=%0d en=%b cw=%b ccw=%b v=%0d expected st=1 en=1 cw=1 ccw=0 v=0",
                        state, enable, cw, ccw, value);
    end
    for (int k = 1; k <= 13; k++) begin
      repeat (RD) tick();
      n_cmp++;
      if (value !== 12'(imin(8 * k, 100))) begin
        n_err++; $display("FAIL ramp_step%0d: got %0d expected %0d", k, value, imin(8 * k, 100));
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (act_vec !== exp_vec() || value !== 12'd100) begin
        n_err++; $display("FAIL ramp_hold: got %h expected %h (value 100)", act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reversal();
    int k, zeros;
    load_sp(-15'sd20);
    k = 0;
    while (value != 12'd0 && k < 100) begin
      tick(); k++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL rev_down: got %h expected %h", act_vec, exp_vec());
      end
    end
    if (k >= 100) begin
      n_cmp++; n_err++; $display("FAIL rev_down_timeout: value %0d expected 0", value);
    end
    zeros = 0; k = 0;
    while (!ccw && k < 50) begin
      tick(); k++;
      if (!enable && !cw && !ccw) zeros++;
    end
    n_cmp++;
    if (zeros != DT || !ccw) begin
      n_err++; $display("FAIL rev_dead: got %0d off clocks ccw=%b expected %0d ccw=1", zeros, ccw, DT);
    end
    for (int s = 1; s <= 4; s++) begin
      repeat (RD) tick();
      n_cmp++;
      if (value !== 12'(imin(8 * s, 20)) || act_vec !== exp_vec()) begin
        n_err++; $display("FAIL rev_up%0d: got %0d expected %0d", s, value, imin(8 * s, 20));
      end
    end
  endtask

  task automatic test_stop_sat();
    int k;
    load_sp(15'h4000);
    k = 0;
    while (value != 12'd4095 && k < 3000) begin
      tick(); k++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL sat_up: got %h expected %h", act_vec, exp_vec());
      end
    end
    repeat (8) tick();
    n_cmp++;
    if (value !== 12'd4095 || ccw !== 1'b1 || cw !== 1'b0) begin
      n_err++; $display("FAIL sat_hold: got v=%0d ccw=%b cw=%b expected v=4095 ccw=1 cw=0", value, ccw, cw);
    end
    run = 1'b0;
    k = 0;
    while (state != 3'd0 && k < 3000) begin
      tick(); k++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL stop_down: got %h expected %h", act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || enable !== 1'b0 || value !== 12'd0 || k >= 3000) begin
      n_err++; $display("FAIL stop_idle: got busy=%b en=%b v=%0d expected 0 0 0", busy, enable, value);
    end
    repeat (DT + 2) tick();
  endtask

  task automatic test_overcurrent();
    load_sp(15'd100);
    run = 1'b1;
    repeat (10) tick();
    adc = 12'd3500; adc_latch = 1'b1;
    tick();
    adc_latch = 1'b0;
    n_cmp++;
    if ({state, fault, enable, cw, ccw, value} !== {3'd3, 1'b1, 3'b000, 12'd0}) begin
      n_err++; $display("FAIL trip1: got st=%0d f=%b en=%b v=%0d expected st=3 f=1 en=0 v=0", state, fault, enable, value);
    end
    repeat (FR - 1) tick();
    n_cmp++;
    if (state !== 3'd3) begin
      n_err++; $display("FAIL retry_early: got %0d expected 3", state);
    end
    tick();
    n_cmp++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_err++; $display("FAIL retry_idle: got st=%0d f=%b expected 0 0", state, fault);
    end
    tick();
    repeat (RD) tick();
    n_cmp++;
    if (state !== 3'd1 || cw !== 1'b1 || value !== 12'd8) begin
      n_err++; $display("FAIL restart: got st=%0d cw=%b v=%0d expected 1 1 8", state, cw, value);
    end
    adc_latch = 1'b1;
    tick();
    adc_latch = 1'b0;
    repeat (FR - 1) tick();
    n_cmp++;
    if (state !== 3'd3 || fault !== 1'b1) begin
      n_err++; $display("FAIL trip2: got st=%0d f=%b expected 3 1", state, fault);
    end
    tick();
    repeat (5) tick();
    n_cmp++;
    if (state !== 3'd4 || fault !== 1'b1 || enable !== 1'b0 || act_vec !== exp_vec()) begin
      n_err++; $display("FAIL lockout: got st=%0d f=%b en=%b expected 4 1 0", state, fault, enable);
    end
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    run = 1'b0;
    n_cmp++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_err++; $display("FAIL clear: got st=%0d f=%b expected 0 0", state, fault);
    end
    tick();
  endtask

  task automatic test_trip_qual();
    run = 1'b1;
    tick();
    repeat (8) tick();
    adc = 12'd3500; adc_latch = 1'b0;
    repeat (3) tick();
    adc = 12'd3000; adc_cmp = 12'd3000; adc_latch = 1'b1;
    tick();
    adc_latch = 1'b0;
    n_cmp++;
    if (state !== 3'd1 || fault !== 1'b0 || act_vec !== exp_vec()) begin
      n_err++; $display("FAIL trip_qual: got st=%0d f=%b expected 1 0", state, fault);
    end
  endtask

  task automatic test_reset_mid_run();
    int k;
    k = 0;
    while (value != 12'd64 && k < 100) begin
      tick(); k++;
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (act_vec !== 20'h0 || k >= 100) begin
      n_err++; $display("FAIL async_reset: got %h expected %h", act_vec, 20'h0);
    end
    tick();
    #2 reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got st=%0d busy=%b expected 0 0", state, busy);
    end
    load_sp(15'd50);
    tick();
    n_cmp++;
    if (state !== 3'd1 || cw !== 1'b1 || act_vec !== exp_vec()) begin
      n_err++; $display("FAIL post_reset_run: got st=%0d cw=%b expected 1 1", state, cw);
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 6000; i++) begin
      run = ($urandom_range(0, 99) < 90);
      setpoint_valid = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 4))
        0: v = int'($urandom_range(1, 200));
        1: v = -int'($urandom_range(1, 200));
        2: v = 0;
        3: v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4000, 16383)) : -int'($urandom_range(4000, 16383));
        default: v = -16384;
      endcase
      setpoint = 15'(v);
      adc_latch = ($urandom_range(0, 99) < 5);
      adc = ($urandom_range(0, 99) < 8) ? 12'($urandom_range(3001, 4095)) : 12'($urandom_range(0, 3000));
      clear_fault = ($urandom_range(0, 199) == 0);
      tick();
      n_cmp++;
      if (act_vec !== exp_vec() || (cw && ccw)) begin
        n_err++; $display("FAIL random[%0d]: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    setpoint_valid = 1'b0; adc_latch = 1'b0; clear_fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_stop_sat();
    test_overcurrent();
    test_trip_qual();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
